// File: rtl/flash_program_sequencer.sv
// Runs a complete SPI flash program/erase sequence (WREN, command, RDSR poll)
// over the SPI master's opcode/data/finalize trigger interface.
module flash_program_sequencer #(
  parameter int unsigned POLL_LIMIT = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [23:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  status_byte,
  output logic [7:0]  m_opcode,
  output logic [23:0] m_addr,
  output logic        m_addr_flag,
  output logic [7:0]  m_write_data,
  input  logic [7:0]  m_read_data,
  output logic        m_opcode_addr_trigger,
  input  logic        m_opcode_addr_completed,
  output logic        m_data_trigger,
  input  logic        m_data_completed,
  output logic        m_finalize_trigger,
  input  logic        m_busy
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 24;

  localparam logic [CNT_W-1:0]  LIMIT        = CNT_W'(POLL_LIMIT);
  localparam logic [DATA_W-1:0] OP_WREN      = 8'h06;
  localparam logic [DATA_W-1:0] OP_RDSR      = 8'h05;
  localparam logic [DATA_W-1:0] OP_SE        = 8'h20;
  localparam logic [DATA_W-1:0] OP_PP        = 8'h02;
  localparam logic [DATA_W-1:0] OP_CE        = 8'hC7;
  localparam logic [DATA_W-1:0] DUMMY_BYTE   = 8'hFF;
  localparam logic [1:0]        CMD_PROG     = 2'd1;
  localparam logic [1:0]        CMD_CHIP     = 2'd2;
  localparam logic [1:0]        CMD_INVALID  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_OP,
    S_WREN_FIN,
    S_CMD_OP,
    S_CMD_DATA,
    S_CMD_FIN,
    S_POLL_OP,
    S_POLL_DATA,
    S_POLL_FIN,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_cmd, w_cmd_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;
  logic [DATA_W-1:0]   r_status, w_status_nxt;
  logic [DATA_W-1:0]   r_opcode, w_opcode_nxt;
  logic [ADDR_W-1:0]   r_maddr, w_maddr_nxt;
  logic                r_aflag, w_aflag_nxt;
  logic [DATA_W-1:0]   r_mwdata, w_mwdata_nxt;
  logic                r_oa_trig, w_oa_trig_nxt;
  logic                r_d_trig, w_d_trig_nxt;
  logic                r_fin, w_fin_nxt;
  logic                r_fin_wait, w_fin_wait_nxt;
  logic [CNT_W-1:0]    r_poll_cnt, w_poll_cnt_nxt;
  logic                r_dc_prev;

  logic                w_dc_rise;
  logic                w_byte_done;
  logic                w_fin_exit;
  logic [CNT_W-1:0]    w_cnt_inc;

  function automatic logic [DATA_W-1:0] cmd_opcode(input logic [1:0] c);
    case (c)
      2'd0:    cmd_opcode = OP_SE;
      2'd1:    cmd_opcode = OP_PP;
      default: cmd_opcode = OP_CE;
    endcase
  endfunction

  assign w_dc_rise   = m_data_completed & ~r_dc_prev;
  assign w_byte_done = r_d_trig & w_dc_rise;
  // Finalize is held at least two cycles, then released once the master is idle.
  assign w_fin_exit  = r_fin_wait & ~m_busy;
  assign w_cnt_inc   = (r_poll_cnt == LIMIT) ? r_poll_cnt : r_poll_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_nxt      = r_cmd;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_error_nxt    = r_error;
    w_status_nxt   = r_status;
    w_opcode_nxt   = r_opcode;
    w_maddr_nxt    = r_maddr;
    w_aflag_nxt    = r_aflag;
    w_mwdata_nxt   = r_mwdata;
    w_oa_trig_nxt  = r_oa_trig;
    w_d_trig_nxt   = r_d_trig;
    w_fin_nxt      = r_fin;
    w_fin_wait_nxt = r_fin_wait;
    w_poll_cnt_nxt = r_poll_cnt;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cmd_nxt   = cmd;
          w_addr_nxt  = addr;
          w_wdata_nxt = wdata;
          w_busy_nxt  = 1'b1;
          if (cmd == CMD_INVALID) begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_error_nxt   = 1'b0;
            w_opcode_nxt  = OP_WREN;
            w_maddr_nxt   = '0;
            w_aflag_nxt   = 1'b0;
            w_fin_nxt     = 1'b0;
            w_oa_trig_nxt = 1'b1;
            w_state_nxt   = S_WREN_OP;
          end
        end
      end

      S_WREN_OP: begin
        if (m_opcode_addr_completed) begin
          w_oa_trig_nxt  = 1'b0;
          w_fin_nxt      = 1'b1;
          w_fin_wait_nxt = 1'b0;
          w_state_nxt    = S_WREN_FIN;
        end
      end

      S_WREN_FIN: begin
        w_fin_wait_nxt = 1'b1;
        if (w_fin_exit) begin
          w_opcode_nxt  = cmd_opcode(r_cmd);
          w_maddr_nxt   = (r_cmd == CMD_CHIP) ? '0 : r_addr;
          w_aflag_nxt   = (r_cmd != CMD_CHIP);
          w_fin_nxt     = 1'b0;
          w_oa_trig_nxt = 1'b1;
          w_state_nxt   = S_CMD_OP;
        end
      end

      S_CMD_OP: begin
        if (m_opcode_addr_completed) begin
          w_oa_trig_nxt = 1'b0;
          if (r_cmd == CMD_PROG) begin
            w_mwdata_nxt = r_wdata;
            w_d_trig_nxt = 1'b1;
            w_state_nxt  = S_CMD_DATA;
          end else begin
            w_fin_nxt      = 1'b1;
            w_fin_wait_nxt = 1'b0;
            w_state_nxt    = S_CMD_FIN;
          end
        end
      end

      S_CMD_DATA: begin
        if (w_byte_done) begin
          w_d_trig_nxt   = 1'b0;
          w_fin_nxt      = 1'b1;
          w_fin_wait_nxt = 1'b0;
          w_state_nxt    = S_CMD_FIN;
        end
      end

      S_CMD_FIN: begin
        w_fin_wait_nxt = 1'b1;
        if (w_fin_exit) begin
          w_opcode_nxt   = OP_RDSR;
          w_maddr_nxt    = '0;
          w_aflag_nxt    = 1'b0;
          w_fin_nxt      = 1'b0;
          w_oa_trig_nxt  = 1'b1;
          w_poll_cnt_nxt = '0;
          w_state_nxt    = S_POLL_OP;
        end
      end

      S_POLL_OP: begin
        if (m_opcode_addr_completed) begin
          w_oa_trig_nxt = 1'b0;
          w_mwdata_nxt  = DUMMY_BYTE;
          w_d_trig_nxt  = 1'b1;
          w_state_nxt   = S_POLL_DATA;
        end
      end

      // Status bytes stream within one CS-low transaction until WIP clears or the limit hits.
      S_POLL_DATA: begin
        if (w_byte_done) begin
          w_d_trig_nxt   = 1'b0;
          w_status_nxt   = m_read_data;
          w_poll_cnt_nxt = w_cnt_inc;
          if (!m_read_data[0]) begin
            w_fin_nxt      = 1'b1;
            w_fin_wait_nxt = 1'b0;
            w_state_nxt    = S_POLL_FIN;
          end else if (w_cnt_inc == LIMIT) begin
            w_error_nxt    = 1'b1;
            w_fin_nxt      = 1'b1;
            w_fin_wait_nxt = 1'b0;
            w_state_nxt    = S_POLL_FIN;
          end
        end else if (!r_d_trig && !m_data_completed) begin
          w_d_trig_nxt = 1'b1;
        end
      end

      S_POLL_FIN: begin
        w_fin_wait_nxt = 1'b1;
        if (w_fin_exit) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_status   <= '0;
      r_opcode   <= '0;
      r_maddr    <= '0;
      r_aflag    <= 1'b0;
      r_mwdata   <= DUMMY_BYTE;
      r_oa_trig  <= 1'b0;
      r_d_trig   <= 1'b0;
      r_fin      <= 1'b1;
      r_fin_wait <= 1'b0;
      r_poll_cnt <= '0;
      r_dc_prev  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_status   <= w_status_nxt;
      r_opcode   <= w_opcode_nxt;
      r_maddr    <= w_maddr_nxt;
      r_aflag    <= w_aflag_nxt;
      r_mwdata   <= w_mwdata_nxt;
      r_oa_trig  <= w_oa_trig_nxt;
      r_d_trig   <= w_d_trig_nxt;
      r_fin      <= w_fin_nxt;
      r_fin_wait <= w_fin_wait_nxt;
      r_poll_cnt <= w_poll_cnt_nxt;
      r_dc_prev  <= m_data_completed;
    end
  end

  assign busy                  = r_busy;
  assign done                  = r_done;
  assign error                 = r_error;
  assign status_byte           = r_status;
  assign m_opcode              = r_opcode;
  assign m_addr                = r_maddr;
  assign m_addr_flag           = r_aflag;
  assign m_write_data          = r_mwdata;
  assign m_opcode_addr_trigger = r_oa_trig;
  assign m_data_trigger        = r_d_trig;
  assign m_finalize_trigger    = r_fin;

endmodule

// File: doc/flash_program_sequencer.md
Name: flash_program_sequencer

Overview:
Drives the SPI flash master's opcode/data/finalize trigger interface to run a complete program or erase sequence.
- Sequence: WREN (0x06) transaction, command transaction, then RDSR (0x05) polling until WIP clears.
- Sits between the control-register logic (requester) and the flash SPI master, so the controller issues a single start and sees done/error instead of hand-sequencing transactions.

Parameters:
POLL_LIMIT, 24'hFFFFFF, max status bytes read in the poll phase before timeout error.

Ports:
clk  in  1  system clock (all logic on posedge).
rst  in  1  synchronous, active-high reset.
start  in  1  begin sequence; sampled only in IDLE.
cmd  in  2  0 = sector erase 0x20, 1 = byte program 0x02, 2 = chip erase 0xC7, 3 = invalid.
addr  in  24  flash address for cmd 0/1.
wdata  in  8  data byte for cmd 1.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle completion pulse.
error  out  1  valid with done; held until next accepted start.
status_byte  out  8  last status register value read.
m_opcode  out  8  to master opcode.
m_addr  out  24  to master addr.
m_addr_flag  out  1  to master addr_flag.
m_write_data  out  8  to master write_data.
m_read_data  in  8  from master read_data.
m_opcode_addr_trigger  out  1  to master.
m_opcode_addr_completed  in  1  from master.
m_data_trigger  out  1  to master.
m_data_completed  in  1  from master.
m_finalize_trigger  out  1  to master.
m_busy  in  1  master interface busy.

Behaviour:
- Reset values:
  - m_finalize_trigger = 1.
  - m_opcode_addr_trigger, m_data_trigger, m_addr_flag, busy, done, error = 0.
  - m_opcode = 0x00, m_addr = 0, m_write_data = 0xFF, status_byte = 0x00.
  - State = IDLE, poll counter = 0.
- Reset mid-sequence: next cycle all outputs at reset values. Finalize asserted releases flash CS. No done pulse.
- Start acceptance:
  - start accepted only in IDLE; start while busy is ignored.
  - On accept: latch cmd/addr/wdata, busy = 1, error = 0.
  - cmd = 3: go to DONE with error = 1, no flash traffic; done pulses 2 cycles after start.
- Transaction primitive OP(opcode, addr_flag):
  - Set m_opcode, m_addr, m_addr_flag; finalize = 0; opcode_addr_trigger = 1.
  - Hold until m_opcode_addr_completed is sampled 1.
- Data primitive BYTE(wd):
  - m_write_data = wd, data_trigger = 1.
  - On sampled rising edge of m_data_completed (registered prev): capture m_read_data, data_trigger = 0.
  - Next byte may start only after m_data_completed is sampled 0.
- FIN primitive:
  - Both triggers = 0, finalize = 1, for a minimum of 2 cycles.
  - Leave when m_busy is sampled 0.
- States and transitions:
  - IDLE -> WREN_OP on start (cmd 0..2).
  - WREN_OP: OP(0x06, 0) -> WREN_FIN -> CMD_OP.
  - CMD_OP: OP(cmd opcode; addr_flag = 1 for cmd 0/1, 0 for chip erase).
    - cmd 1 -> CMD_DATA: BYTE(wdata) -> CMD_FIN.
    - Otherwise -> CMD_FIN.
  - CMD_FIN -> POLL_OP: OP(0x05, 0), poll counter = 0.
  - POLL_DATA: BYTE(0xFF); on capture: status_byte <= read value, counter += 1.
    - bit0 = 0 -> POLL_FIN (success).
    - Else if counter == POLL_LIMIT -> POLL_FIN with error = 1.
    - Else repeat POLL_DATA within the same CS-low transaction.
  - POLL_FIN -> DONE.
  - DONE: done = 1 for one cycle, busy = 0 -> IDLE.
- Boundary cases:
  - The WREL bit (SR bit1) is not checked.
  - Poll counter saturates at POLL_LIMIT and does not wrap.
  - POLL_LIMIT = 1 means exactly one status read.
  - m_opcode_addr_completed already high on entry to an OP state: OP completes the next cycle. This is legal.

Test Plan:
1. Byte program: rst, start with cmd = 1, addr = 0x012345, wdata = 0xA5; master model returns SR 0x03, 0x03, 0x00.
   - Opcode order 0x06, 0x02, 0x05.
   - m_addr = 0x012345 with addr_flag = 1 only on 0x02; m_write_data = 0xA5.
   - 3 poll bytes; status_byte = 0x00; done with error = 0.
2. Chip erase: cmd = 2.
   - Opcode 0xC7 with addr_flag = 0, no data byte.
   - Finalize asserted between every transaction; done with error = 0.
3. Timeout: POLL_LIMIT = 4, SR always 0x01.
   - Exactly 4 poll bytes, status_byte = 0x01.
   - done with error = 1, finalize = 1 afterwards.
4. Invalid cmd = 3.
   - No trigger ever asserted; done pulses 2 cycles after start with error = 1.
   - A following valid start clears error.
5. rst asserted during POLL_DATA.
   - Next cycle: data_trigger = 0, finalize = 1, busy = 0, no done pulse.
   - A new start then runs the full sequence correctly.
6. start pulsed again while busy (in CMD_OP).
   - Ignored: single sequence, single done pulse.
